vga_trace_sweep: RTL and testbench
==================================

// Module: vga_trace_sweep
// PURPOSE
//  Multi-channel scope-trace sweep generator for the 160-column VGA plot pane.
//  Per sweep: walks plot columns 0..X_COLS-1 and, per column, each channel in turn.
//  Emits one point per cycle: column, channel, sample-buffer read address, trace colour.
//  Sits between the per-channel sample buffers and the line/pixel drawer.
//  Adds start/finish handshake, per-channel colour and a programmable time-division step.
// PARAMETERS
//  X_COLS     160             plot columns per sweep
//  XW         8               CounterX width; 2**XW >= X_COLS
//  ADDR_W     11              sample-buffer read address width
//  DIV_W      2               time_division width; step = time_division+1 (1..2**DIV_W)
//  NUM_CH     2               traces (>=1); CHW = max(1,$clog2(NUM_CH))
//  COLOR_W    12              RGB444 colour width
//  CH_COLORS  {12'h0F0,12'hF00}  NUM_CH*COLOR_W packed colour table; ch0 in LSBs
// PORTS
//  clk            in   1         system clock; all logic posedge clk
//  reset          in   1         synchronous, active-high reset
//  start          in   1         begin sweep; honoured only in IDLE
//  enable         in   1         0 = stall; sweep state and all counters hold
//  time_division  in   DIV_W     sampled on accepted start only
//  pix_ready      in   1         drawer accepts point (VGA_SWEEP_BP_EN only)
//  CounterX       out  XW        current column
//  ch_sel         out  CHW       current channel
//  read_CounterX  out  ADDR_W    sample-buffer read address
//  color          out  COLOR_W   CH_COLORS slice for ch_sel
//  pix_valid      out  1         point on outputs is valid
//  busy           out  1         high in SWEEP
//  finished       out  1         one-cycle pulse after last point accepted
// BEHAVIOUR
//  Reset: state=IDLE; CounterX=0, ch_sel=0, read_CounterX=0, pix_valid=0, busy=0, finished=0.
//    color = CH_COLORS[ch0].
//  Reset wins over every input in any state; a sweep interrupted mid-way is abandoned, no finished.
//  States: IDLE -> SWEEP -> DONE -> IDLE.
//  IDLE, start=1: latch step=time_division+1 ({1'b0,td}+1, DIV_W+1 bits).
//    Clear counters; next cycle SWEEP.
//  SWEEP: pix_valid = enable. A point is accepted when pix_valid (& pix_ready).
//  Accept (ch_sel<NUM_CH-1): ch_sel++; CounterX and read_CounterX hold.
//  Accept (ch_sel==NUM_CH-1, CounterX<X_COLS-1): ch_sel=0, CounterX++, read_CounterX+=step.
//  Accept (last point, CounterX==X_COLS-1 & ch_sel==NUM_CH-1): -> DONE. CounterX, ch_sel hold.
//  read_CounterX wraps modulo 2**ADDR_W: e.g. 2046+2 -> 0. It is never clamped.
//  enable=0 in SWEEP: pix_valid=0, nothing advances; resumes on the same point.
//  DONE: finished=1, busy=0, pix_valid=0 for exactly one cycle. Counters reset to 0; -> IDLE.
//  start in SWEEP or DONE: ignored, not queued.
//  start held high: next sweep begins the cycle after the return to IDLE.
//  Latency: start accepted at cycle t -> first pix_valid at t+1 (if enable).
//  Sweep length = X_COLS*NUM_CH accepted points.
//  color is combinational from ch_sel; all other outputs are registered.
// CONFIGURATION
//  VGA_SWEEP_BP_EN defined: pix_ready gates acceptance.
//    With pix_valid=1 & pix_ready=0, outputs must hold stable until pix_ready=1.
//  VGA_SWEEP_BP_EN undefined: pix_ready port absent; acceptance = pix_valid.
// STRUCTURE
//  vga_pkg: sweep_state_t enum (IDLE, SWEEP, DONE); default X_COLS/colour constants.
//  Sub-module vga_addr_step: step latch and modulo ADDR_W accumulator.
//    Controls: clear, load step, advance. Everything else is in the top module.
// TESTING
//  Test 1: reset, then start with td=0, NUM_CH=2, enable=1.
//    Expect 320 valid points; read_CounterX 0..159; finished 1 cycle at t+321.
//  Test 2: td=3.
//    Expect read_CounterX to step by 4: after col 159 it is 636; finished once.
//  Test 3: ADDR_W=4 (2**ADDR_W=16), td=3.
//    Expect read_CounterX 0,4,8,12,0: wraps, no clamp.
//  Test 4: enable low for 5 cycles mid-sweep at col 37/ch1.
//    Expect pix_valid=0 and outputs frozen; resumes at col 37/ch1; point count is still 320.
//  Test 5: reset asserted at col 80.
//    Expect all outputs zero next cycle and no finished; a new start runs a full sweep.
//  Test 6: (BP_EN) pix_ready toggles 1010..., plus start pulses mid-sweep.
//    Expect outputs stable while stalled, starts ignored, and exactly 320 accepted points.

Source files
------------

// File: rtl/vga_trace_sweep_pkg.sv
// Shared types and default constants for the scope-trace sweep generator.
// Channel colours are packed with ch0 in the LSBs.
package vga_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } sweep_state_t;

  localparam int X_COLS_DEF  = 160;
  localparam int NUM_CH_DEF  = 2;
  localparam int COLOR_W_DEF = 12;
  localparam logic [NUM_CH_DEF*COLOR_W_DEF-1:0] CH_COLORS_DEF = {12'h0F0, 12'hF00};

  function automatic int chw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vga_trace_sweep_if.sv
// Control and point bus between the sweep controller and the pixel drawer.
// pix_ready exists only when VGA_SWEEP_BP_EN is defined.
interface vga_trace_sweep_if
  import vga_pkg::*;
#(
  parameter int XW      = 8,
  parameter int ADDR_W  = 11,
  parameter int DIV_W   = 2,
  parameter int NUM_CH  = NUM_CH_DEF,
  parameter int COLOR_W = COLOR_W_DEF
);
  localparam int CHW = chw(NUM_CH);

  logic               start;
  logic               enable;
  logic [DIV_W-1:0]   time_division;
`ifdef VGA_SWEEP_BP_EN
  logic               pix_ready;
`endif
  logic [XW-1:0]      CounterX;
  logic [CHW-1:0]     ch_sel;
  logic [ADDR_W-1:0]  read_CounterX;
  logic [COLOR_W-1:0] color;
  logic               pix_valid;
  logic               busy;
  logic               finished;

  modport master (
`ifdef VGA_SWEEP_BP_EN
    output pix_ready,
`endif
    output start, enable, time_division,
    input  CounterX, ch_sel, read_CounterX, color, pix_valid, busy, finished
  );

  modport slave (
`ifdef VGA_SWEEP_BP_EN
    input  pix_ready,
`endif
    input  start, enable, time_division,
    output CounterX, ch_sel, read_CounterX, color, pix_valid, busy, finished
  );

endinterface

// File: rtl/vga_trace_sweep_addr_step.sv
// Sample-buffer read address: step latched on start, accumulator wraps modulo 2**ADDR_W.
// Registered; clear has priority over advance.
module vga_addr_step #(
  parameter int ADDR_W = 11,
  parameter int DIV_W  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              load,
  input  logic [DIV_W-1:0]  time_division,
  input  logic              advance,
  output logic [ADDR_W-1:0] addr
);

  logic [DIV_W:0] step;

  always_ff @(posedge clk) begin
    if (reset) begin
      step <= (DIV_W+1)'(1);
      addr <= '0;
    end else begin
      if (load)
        step <= {1'b0, time_division} + (DIV_W+1)'(1);
      if (clear)
        addr <= '0;
      else if (advance)
        addr <= addr + ADDR_W'(step);
    end
  end

endmodule

// File: rtl/vga_trace_sweep.sv
// Sweeps plot columns x channels, one point per cycle; first point the cycle after start.
// Backpressure via pix_ready only with VGA_SWEEP_BP_EN; a stalled point holds stable.
module vga_trace_sweep
  import vga_pkg::*;
#(
  parameter int X_COLS  = X_COLS_DEF,
  parameter int XW      = 8,
  parameter int ADDR_W  = 11,
  parameter int DIV_W   = 2,
  parameter int NUM_CH  = NUM_CH_DEF,
  parameter int COLOR_W = COLOR_W_DEF,
  parameter logic [NUM_CH*COLOR_W-1:0] CH_COLORS = CH_COLORS_DEF
) (
  input logic              clk,
  input logic              reset,
  vga_trace_sweep_if.slave bus
);

  localparam int CHW = chw(NUM_CH);

  sweep_state_t      state, nxt;
  logic [XW-1:0]     cx;
  logic [CHW-1:0]    ch;
  logic [ADDR_W-1:0] rd_addr;
  logic              pv, bsy, fin;
  logic              accept, stall, last_ch, last_col, last_pt;
  logic              clr, load, adv;

`ifdef VGA_SWEEP_BP_EN
  assign accept = pv & bus.pix_ready;
  assign stall  = pv & ~bus.pix_ready;
`else
  assign accept = pv;
  assign stall  = 1'b0;
`endif

  assign last_ch  = (ch == CHW'(NUM_CH-1));
  assign last_col = (cx == XW'(X_COLS-1));
  assign last_pt  = accept & last_ch & last_col;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt  = state;
    load = 1'b0;
    clr  = 1'b0;
    adv  = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          nxt  = SWEEP;
          load = 1'b1;
          clr  = 1'b1;
        end
      end
      SWEEP: begin
        if (last_pt) nxt = DONE;
        adv = accept & last_ch & ~last_col;
      end
      DONE: begin
        nxt = IDLE;
        clr = 1'b1;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cx  <= '0;
      ch  <= '0;
      pv  <= 1'b0;
      bsy <= 1'b0;
      fin <= 1'b0;
    end else begin
      bsy <= (nxt == SWEEP);
      fin <= (state == SWEEP) & last_pt;
      // A stalled point keeps valid asserted even if enable drops meanwhile
      pv  <= (nxt == SWEEP) & (stall | bus.enable);
      if (clr) begin
        cx <= '0;
        ch <= '0;
      end else if (state == SWEEP && accept && !last_pt) begin
        if (!last_ch) begin
          ch <= ch + CHW'(1);
        end else begin
          ch <= '0;
          cx <= cx + XW'(1);
        end
      end
    end
  end

  vga_addr_step #(.ADDR_W(ADDR_W), .DIV_W(DIV_W)) u_addr_step (
    .clk           (clk),
    .reset         (reset),
    .clear         (clr),
    .load          (load),
    .time_division (bus.time_division),
    .advance       (adv),
    .addr          (rd_addr)
  );

  assign bus.CounterX      = cx;
  assign bus.ch_sel        = ch;
  assign bus.read_CounterX = rd_addr;
  assign bus.color         = CH_COLORS[ch*COLOR_W +: COLOR_W];
  assign bus.pix_valid     = pv;
  assign bus.busy          = bsy;
  assign bus.finished      = fin;

endmodule

// File: tb/tb_vga_trace_sweep.sv
// Directed bench: table of full sweeps on an ADDR_W=11 and an ADDR_W=4 instance,
// plus hand sequences for mid-sweep reset and start held high.
`timescale 1ns/1ps
module tb_vga_trace_sweep;
  import vga_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       sel;
  logic       start, enable, ready;
  logic [1:0] td;

  always #5 clk = ~clk;

  vga_trace_sweep_if #(.ADDR_W(11)) bus ();
  vga_trace_sweep_if #(.ADDR_W(4))  bus4 ();

  assign bus.start          = start & ~sel;
  assign bus4.start         = start & sel;
  assign bus.enable         = enable;
  assign bus4.enable        = enable;
  assign bus.time_division  = td;
  assign bus4.time_division = td;
`ifdef VGA_SWEEP_BP_EN
  assign bus.pix_ready  = ready;
  assign bus4.pix_ready = ready;
`endif

  vga_trace_sweep #(.ADDR_W(11)) dut  (.clk(clk), .reset(reset), .bus(bus));
  vga_trace_sweep #(.ADDR_W(4))  dut4 (.clk(clk), .reset(reset), .bus(bus4));

  logic [10:0] o_addr;
  logic [7:0]  o_cx;
  logic [0:0]  o_ch;
  logic [11:0] o_col;
  logic        o_pv, o_bsy, o_fin;

  always_comb begin
    if (sel) begin
      o_addr = {7'b0, bus4.read_CounterX};
      o_cx   = bus4.CounterX;
      o_ch   = bus4.ch_sel;
      o_col  = bus4.color;
      o_pv   = bus4.pix_valid;
      o_bsy  = bus4.busy;
      o_fin  = bus4.finished;
    end else begin
      o_addr = bus.read_CounterX;
      o_cx   = bus.CounterX;
      o_ch   = bus.ch_sel;
      o_col  = bus.color;
      o_pv   = bus.pix_valid;
      o_bsy  = bus.busy;
      o_fin  = bus.finished;
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    bit use4;       // run on the ADDR_W=4 instance
    int td;
    int stall_col;  // drop enable for 5 cycles after this column's ch0 point (-1: none)
    int spulse;     // cycle at which a 3-cycle start burst is driven mid-sweep (-1: none)
    bit bp;         // toggle pix_ready 1010...
    int exp_pts;
    int exp_last;   // read_CounterX of the final point
    int exp_fin;    // cycle of finished, counted from the start cycle
  } vec_t;

  vec_t vt[$];

  task automatic run_vec(input vec_t v, input int idx);
    int pts = 0, bad = 0, fin_n = 0, fin_c = -1, last_addr = -1;
    int stall_bad = 0, hold_bad = 0, post_bad = 0;
    int ex = 0, ec = 0, step, modv, stall_left = 0, stall_chk = 0;
    bit hold_chk = 0;
    bit rdy;
    logic [32:0] held = '0;
    step   = v.td + 1;
    modv   = v.use4 ? 16 : 2048;
    sel    = v.use4;
    td     = 2'(v.td);
    enable = 1'b1;
    ready  = 1'b1;
    @(negedge clk);
    start = 1'b1;
    for (int cyc = 1; cyc <= 1200 && (fin_c < 0 || cyc <= fin_c + 3); cyc++) begin
      @(negedge clk);
      start = (v.spulse >= 0 && cyc >= v.spulse && cyc < v.spulse + 3);
      rdy   = v.bp ? cyc[0] : 1'b1;
      ready = rdy;
      if (hold_chk && {o_cx, o_ch, o_addr, o_pv, o_col} !== held) hold_bad++;
      hold_chk = 0;
      if (stall_chk > 0) begin
        if (o_pv !== 1'b0 || o_cx != 8'(v.stall_col) || o_ch != 1'b1) stall_bad++;
        stall_chk--;
      end
      if (o_pv === 1'b1 && rdy) begin
        if (o_cx != 8'(ex) || o_ch != 1'(ec) || int'(o_addr) != (ex * step) % modv ||
            o_col != (ec == 1 ? 12'h0F0 : 12'hF00) || o_bsy !== 1'b1) bad++;
        last_addr = int'(o_addr);
        pts++;
        if (ex == v.stall_col && ec == 0) begin
          stall_left = 5;
          stall_chk  = 5;
        end
        if (ec == 1) begin ec = 0; ex++; end
        else ec++;
      end else if (o_pv === 1'b1) begin
        held     = {o_cx, o_ch, o_addr, o_pv, o_col};
        hold_chk = 1;
      end
      if (o_fin === 1'b1) begin
        fin_n++;
        if (fin_c < 0) fin_c = cyc;
        if (o_bsy !== 1'b0 || o_pv !== 1'b0) post_bad++;
      end
      if (fin_c >= 0 && cyc == fin_c + 1 &&
          (o_pv !== 1'b0 || o_bsy !== 1'b0 || o_cx != 0 || o_ch != 0 || o_addr != 0)) post_bad++;
      if (fin_c >= 0 && cyc > fin_c && o_pv === 1'b1) post_bad++;
      enable = (stall_left > 0) ? 1'b0 : 1'b1;
      if (stall_left > 0) stall_left--;
    end
    start = 1'b0;
    enable = 1'b1;
    ready = 1'b1;
    check($sformatf("v%0d_points", idx), pts, v.exp_pts);
    check($sformatf("v%0d_last_addr", idx), last_addr, v.exp_last);
    check($sformatf("v%0d_finished_count", idx), fin_n, 1);
    check($sformatf("v%0d_finished_cycle", idx), fin_c, v.exp_fin);
    check($sformatf("v%0d_point_sequence_errors", idx), bad, 0);
    check($sformatf("v%0d_post_done_errors", idx), post_bad, 0);
    if (v.stall_col >= 0) check($sformatf("v%0d_stall_errors", idx), stall_bad, 0);
    if (v.bp) check($sformatf("v%0d_hold_errors", idx), hold_bad, 0);
  endtask

  initial begin
    int cnt, fin_c, seen;
    reset = 1'b1; sel = 1'b0; start = 1'b0; enable = 1'b1; ready = 1'b1; td = 2'd0;

    vt.push_back('{0, 0, -1, -1, 0, 320, 159, 321});
    vt.push_back('{0, 3, -1, 50, 0, 320, 636, 321});
    vt.push_back('{1, 3, -1, -1, 0, 320, 12,  321});
    vt.push_back('{0, 2, 37, -1, 0, 320, 477, 326});
    vt.push_back('{1, 0, -1, -1, 0, 320, 15,  321});
`ifdef VGA_SWEEP_BP_EN
    vt.push_back('{0, 2, -1, 100, 1, 320, 477, 640});
`endif

    repeat (2) @(negedge clk);
    check("reset_outputs", {24'b0, o_cx, o_ch, o_addr, o_pv, o_bsy, o_fin}, 0);
    check("reset_color", o_col, 12'hF00);
    sel = 1'b1;
    #1;
    check("reset_outputs_addr4", {24'b0, o_cx, o_ch, o_addr, o_pv, o_bsy, o_fin}, 0);
    sel = 1'b0;
    reset = 1'b0;
    @(negedge clk);

    foreach (vt[i]) run_vec(vt[i], i);

    // Reset in the middle of a sweep at column 80
    sel = 1'b0; td = 2'd1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    seen = 0;
    for (int c = 0; c < 400 && !seen; c++) begin
      if (o_pv === 1'b1 && o_cx == 8'd80 && o_ch == 1'b0) seen = 1;
      else @(negedge clk);
    end
    check("reset_mid_reached_col80", seen, 1);
    reset = 1'b1;
    @(negedge clk);
    check("reset_mid_outputs", {24'b0, o_cx, o_ch, o_addr, o_pv, o_bsy, o_fin}, 0);
    reset = 1'b0;
    cnt = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (o_fin !== 1'b0 || o_pv !== 1'b0) cnt++;
    end
    check("reset_mid_no_activity", cnt, 0);

    // Start held high: next sweep begins right after the return to IDLE
    td = 2'd0;
    @(negedge clk); start = 1'b1;
    fin_c = -1;
    for (int c = 1; c <= 400 && fin_c < 0; c++) begin
      @(negedge clk);
      if (o_fin === 1'b1) fin_c = c;
    end
    check("held_start_finished_cycle", fin_c, 321);
    @(negedge clk);
    check("held_start_idle_gap", {o_pv, o_bsy}, 2'b00);
    @(negedge clk);
    check("held_start_restart", {o_pv, o_bsy, o_cx, o_ch, o_addr}, {2'b11, 20'b0});
    start = 1'b0;
    seen = 0;
    for (int c = 0; c < 400 && !seen; c++) begin
      @(negedge clk);
      if (o_fin === 1'b1) seen = 1;
    end
    check("held_start_second_finish", seen, 1);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
